fifo_drain: RTL and testbench
=============================

// Module: fifo_drain
// PURPOSE
//  Read-side controller for the byte FIFO: issues FIFO reads, absorbs the FIFO's registered
//  one-cycle read latency, and presents words as a valid/ready stream with no bubbles.
//  Sits between the FIFO read port and any downstream consumer (UART TX, packet framer).
//  Never reads an empty FIFO and never drops a word: reads are credit-limited by the local buffer.
// PARAMETERS
//  DATA_W   8   FIFO / stream data width
//  BUF_D    2   local buffer depth in entries; >=2 (2 = minimum for full throughput)
//  CNT_W    16  width of pop_count statistics counter
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst_n         in   1       asynchronous active-low reset
//  fifo_empty    in   1       FIFO has no readable word this cycle
//  fifo_rd_en    out  1       FIFO read strobe (one word per asserted cycle)
//  fifo_rd_data  in   DATA_W  FIFO read data, valid the cycle after fifo_rd_en
//  m_valid       out  1       stream word available
//  m_ready       in   1       consumer accepts the word; transfer when m_valid && m_ready
//  m_data        out  DATA_W  stream data (head of local buffer)
//  flush         in   1       synchronous discard of buffered and in-flight words
//  idle          out  1       buffer empty and no read in flight
//  pop_count     out  CNT_W   number of stream transfers since reset, wraps
// BEHAVIOUR
//  Reset: fifo_rd_en=0, m_valid=0, m_data=0, idle=1, pop_count=0, buffer count=0, inflight=0.
//  inflight: register = fifo_rd_en of previous cycle (0 when flush asserted in that cycle).
//  pop = m_valid && m_ready.
//  fifo_rd_en = !fifo_empty && !flush && (count + inflight - pop) < BUF_D  (combinational,
//   depends on m_ready; sum computed in $clog2(BUF_D)+2 bits, no underflow since pop<=count).
//  Capture: when inflight==1 and !flush, fifo_rd_data written to buffer tail this edge.
//  Latency: fifo_rd_en at cycle N -> data on fifo_rd_data at N+1 -> m_valid=1 at N+2.
//  Buffer: circular, BUF_D entries, head/tail wrap at BUF_D (non-power-of-2 allowed).
//   Push and pop same cycle: both occur, count unchanged; if count==0 only push can occur.
//   m_valid = (count!=0); m_data = mem[head], held stable while m_valid && !m_ready.
//  Steady state with m_ready=1 and FIFO non-empty: one transfer per cycle, no bubbles.
//  m_ready=0 with FIFO non-empty: at most BUF_D words leave the FIFO, then fifo_rd_en=0.
//  Full: count==BUF_D never overflows; credit rule guarantees a slot for every in-flight word.
//  flush: next edge count=0, head=tail=0, word arriving this cycle discarded, fifo_rd_en=0
//   this cycle; m_valid=0 next cycle; pop this cycle still counted in pop_count.
//  pop_count increments by 1 per pop, wraps 2^CNT_W-1 -> 0.
//  idle = (count==0) && (inflight==0).
//  Async reset mid-transfer: all state cleared immediately; in-flight word lost (FIFO
//   pointers reset on the same rst_n, so no desync).
// STRUCTURE
//  fifo_pkg: DATA_W default constant, shared with the FIFO; typedef logic [DATA_W-1:0] fifo_word_t.
//  Sub-module drain_buf: BUF_D-entry circular buffer (push, pop, flush, count, head data).
//  Top: credit logic, inflight register, pop_count counter, idle.
// TESTING
//  1 Reset, FIFO holding 0x11,0x22,0x33, m_ready=1 -> rd_en 3 consecutive cycles, m_valid
//    from cycle 2 for 3 cycles, m_data 0x11,0x22,0x33, pop_count=3, idle=1 after.
//  2 FIFO holding 10 words, m_ready=0 -> exactly BUF_D=2 rd_en pulses, m_data=first word held
//    stable; then m_ready=1 -> 10 words out in order, one per cycle, no gaps.
//  3 fifo_empty=1 throughout, m_ready toggling -> fifo_rd_en never 1, m_valid never 1.
//  4 Buffer holding 2 words + 1 in flight (BUF_D=3), flush 1 cycle -> next cycle m_valid=0,
//    idle=1, in-flight word never appears; next FIFO word then delivered normally.
//  5 pop_count preset path: 65537 transfers with CNT_W=16 -> pop_count=1.
//  6 rst_n low mid-burst (m_valid=1, inflight=1) -> outputs at reset values same cycle,
//    no stream transfer until FIFO refilled after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the byte FIFO and its read-side controller.
//   DATA_W is the default word width used by the FIFO and by fifo_drain, and
//   fifo_word_t is the matching word type. credit_bits() gives the width used
//   for the read-credit sum in fifo_drain. That width must hold count (up to
//   BUF_D) plus one in-flight word with headroom, so the sum never wraps.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] fifo_word_t;

    // Width of the credit arithmetic for a local buffer of 'depth' entries.
    function automatic int credit_bits(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage

// File: rtl/drain_buf.sv
// ---------------------------------------------------------------------------
// drain_buf
//   Small circular buffer that holds words returned by the FIFO until the
//   downstream consumer takes them. Head and tail wrap at BUF_D, so
//   non-power-of-two depths work. The caller guarantees that a push never
//   arrives while the buffer is full; the credit logic in fifo_drain enforces
//   this.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   push       in   write push_data at the tail this edge
//   push_data  in   word to store
//   pop        in   remove the head word this edge (ignored when empty)
//   flush      in   empty the buffer and rewind both pointers; overrides push/pop
//   count      out  number of stored words, 0..BUF_D
//   head_data  out  word at the head of the buffer
// ---------------------------------------------------------------------------
module drain_buf #(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int BUF_D  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(BUF_D+1)-1:0]   count,
    output logic [DATA_W-1:0]            head_data
);

    localparam int PW = $clog2(BUF_D);
    localparam int CW = $clog2(BUF_D + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(BUF_D - 1);

    logic [DATA_W-1:0] mem_q [BUF_D];
    logic [DATA_W-1:0] mem_d [BUF_D];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              pop_ok;

    // Advance a pointer by one slot, wrapping explicitly at BUF_D rather than
    // relying on natural binary rollover.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Next-state logic. A flush wins over everything, including a word that
    // arrives in the same cycle. A pop of an empty buffer is ignored, so with
    // count==0 only the push side can take effect.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_ok  = pop && (count_q != '0);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = push_data;
                tail_d        = ptr_next(tail_q);
            end
            if (pop_ok) begin
                head_d = ptr_next(head_q);
            end
            case ({push, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers. Storage is cleared on reset so that head_data reads 0
    // straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[head_q];

endmodule

// File: rtl/fifo_drain.sv
// ---------------------------------------------------------------------------
// fifo_drain
//   Read-side controller for the byte FIFO. It issues FIFO reads, absorbs the
//   FIFO's one-cycle registered read latency, and presents the words as a
//   valid/ready stream with no bubbles. Reads are credit-limited by the local
//   buffer. Every word already in flight has a reserved slot, so nothing is
//   ever dropped, and the controller never reads an empty FIFO.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   fifo_empty    in   FIFO has no readable word this cycle
//   fifo_rd_en    out  FIFO read strobe, one word per asserted cycle
//   fifo_rd_data  in   FIFO read data, valid the cycle after fifo_rd_en
//   m_valid       out  stream word available
//   m_ready       in   consumer accepts the word this cycle
//   m_data        out  stream data (head of the local buffer)
//   flush         in   synchronous discard of buffered and in-flight words
//   idle          out  buffer empty and no read in flight
//   pop_count     out  number of stream transfers since reset, wraps
// ---------------------------------------------------------------------------
module fifo_drain #(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int BUF_D  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    input  logic              flush,
    output logic              idle,
    output logic [CNT_W-1:0]  pop_count
);

    import fifo_pkg::*;

    localparam int CW = $clog2(BUF_D + 1);
    localparam int SW = credit_bits(BUF_D);

    logic [CW-1:0]    buf_count;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] pop_count_q, pop_count_d;
    logic             pop;
    logic             push;
    logic [SW-1:0]    credit_used;

    // Local buffer holding returned words until the consumer takes them.
    drain_buf #(
        .DATA_W (DATA_W),
        .BUF_D  (BUF_D)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .flush     (flush),
        .count     (buf_count),
        .head_data (m_data)
    );

    // Credit logic. A slot is free when the words held, plus the word on its
    // way back from the FIFO, minus the word leaving this cycle, is below
    // BUF_D. Counting this cycle's pop is what lets a depth of 2 sustain one
    // word per cycle. It also makes the read strobe depend combinationally on
    // m_ready. Because pop implies count>=1, the subtraction cannot
    // underflow.
    always_comb begin
        pop         = m_valid && m_ready;
        credit_used = SW'(buf_count) + SW'(inflight_q) - SW'(pop);
        fifo_rd_en  = !fifo_empty && !flush && (credit_used < SW'(BUF_D));
        push        = inflight_q && !flush;
        inflight_d  = fifo_rd_en;
        pop_count_d = pop_count_q + CNT_W'(pop);
    end

    // Read-in-flight marker and transfer counter. A pop that happens in a
    // flush cycle is still a real transfer, so it is still counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q  <= 1'b0;
            pop_count_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            pop_count_q <= pop_count_d;
        end
    end

    assign m_valid   = (buf_count != '0);
    assign idle      = (buf_count == '0) && !inflight_q;
    assign pop_count = pop_count_q;

endmodule

// File: tb/tb_fifo_drain.sv
// ---------------------------------------------------------------------------
// tb_fifo_drain
//   Directed bench for fifo_drain. Instance 0 uses BUF_D=2 and instance 1 uses
//   BUF_D=3. Each instance reads from a small behavioural FIFO with a
//   registered read port, and that FIFO is cleared by the same rst_n. Inputs
//   change on the falling edge, and outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_fifo_drain;

    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic [1:0]       fifo_empty;
    logic [1:0]       fifo_rd_en;
    logic [1:0]       m_valid;
    logic [1:0]       m_ready;
    logic [1:0]       flush;
    logic [1:0]       idle;
    fifo_word_t       rd_data   [2];
    fifo_word_t       m_data    [2];
    logic [15:0]      pop_count [2];

    fifo_word_t       fifo_mem [2][256];
    logic [31:0]      rd_ptr [2];
    logic [31:0]      wr_ptr [2] = '{32'd0, 32'd0};
    logic             endless = 1'b0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       ready;
        logic       fl;
        logic       rd_en;
        logic       valid;
        fifo_word_t data;
        logic       idle;
    } vec_t;

    vec_t t1 [14];
    vec_t t4 [9];

    fifo_drain #(.DATA_W(8), .BUF_D(2), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty[0]),
        .fifo_rd_en   (fifo_rd_en[0]),
        .fifo_rd_data (rd_data[0]),
        .m_valid      (m_valid[0]),
        .m_ready      (m_ready[0]),
        .m_data       (m_data[0]),
        .flush        (flush[0]),
        .idle         (idle[0]),
        .pop_count    (pop_count[0])
    );

    fifo_drain #(.DATA_W(8), .BUF_D(3), .CNT_W(16)) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty[1]),
        .fifo_rd_en   (fifo_rd_en[1]),
        .fifo_rd_data (rd_data[1]),
        .m_valid      (m_valid[1]),
        .m_ready      (m_ready[1]),
        .m_data       (m_data[1]),
        .flush        (flush[1]),
        .idle         (idle[1]),
        .pop_count    (pop_count[1])
    );

    // Empty flag of each behavioural FIFO. In endless mode, FIFO 0 never runs
    // dry and supplies its read pointer as data.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            fifo_empty[k] = (rd_ptr[k] == wr_ptr[k]) && !(endless && (k == 0));
        end
    end

    // Registered read port. A reset throws away every stored word, just as
    // the real FIFO does on rst_n.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                rd_ptr[k]  <= wr_ptr[k];
                rd_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (fifo_rd_en[k]) begin
                    rd_data[k] <= (endless && (k == 0)) ? rd_ptr[k][7:0]
                                                        : fifo_mem[k][rd_ptr[k][7:0]];
                    rd_ptr[k]  <= rd_ptr[k] + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic ready, input logic fl);
        m_ready[which] = ready;
        flush[which]   = fl;
        #1;
    endtask

    task automatic pushWord(input int which, input fifo_word_t d);
        fifo_mem[which][wr_ptr[which][7:0]] = d;
        wr_ptr[which] = wr_ptr[which] + 1;
    endtask

    task automatic checkRow(input int which, input vec_t v, input string tag);
        checkOutput({tag, "_rd_en"}, 32'(fifo_rd_en[which]), 32'(v.rd_en));
        checkOutput({tag, "_valid"}, 32'(m_valid[which]),    32'(v.valid));
        checkOutput({tag, "_idle"},  32'(idle[which]),       32'(v.idle));
        if (v.valid)
            checkOutput({tag, "_data"}, 32'(m_data[which]), 32'(v.data));
    endtask

    task automatic checkResetState(input int which, input string tag);
        checkOutput({tag, "_rd_en"}, 32'(fifo_rd_en[which]), 32'd0);
        checkOutput({tag, "_valid"}, 32'(m_valid[which]),    32'd0);
        checkOutput({tag, "_data"},  32'(m_data[which]),     32'd0);
        checkOutput({tag, "_idle"},  32'(idle[which]),       32'd1);
        checkOutput({tag, "_pop"},   32'(pop_count[which]),  32'd0);
    endtask

    initial begin
        int rdcnt;
        int pops;
        int cyc;
        bit done;

        // Test 1: three words drained with m_ready high. After that, the FIFO
        // stays empty while m_ready toggles, and a flush is applied on an
        // empty buffer.
        t1[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        t1[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        t1[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
        t1[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0};
        t1[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0};
        t1[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        t1[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        t1[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        t1[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        t1[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        t1[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        t1[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        t1[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        t1[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};

        // Test 4 (BUF_D=3): two words buffered plus one in flight, a one-cycle
        // flush, and then the next FIFO word delivered normally. C2 must never
        // appear.
        t4[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        t4[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        t4[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hC0, 1'b0};
        t4[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hC0, 1'b0};
        t4[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        t4[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        t4[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0};
        t4[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hC4, 1'b0};
        t4[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};

        rst_n   = 1'b0;
        m_ready = 2'b00;
        flush   = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkResetState(0, "reset_b2");
        checkResetState(1, "reset_b3");

        @(negedge clk);
        rst_n = 1'b1;
        pushWord(0, 8'h11);
        pushWord(0, 8'h22);
        pushWord(0, 8'h33);
        $display("[TB] test 1/3: basic drain, empty FIFO, idle flush");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, t1[i].ready, t1[i].fl);
            checkRow(0, t1[i], $sformatf("t1_row%0d", i));
            @(negedge clk);
        end
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("t1_pop_count", 32'(pop_count[0]), 32'd3);

        // Test 2: the consumer stalls with ten words waiting. Only BUF_D reads
        // may be issued, and then all ten words must stream out back to back.
        $display("[TB] test 2: stalled consumer then full-rate drain");
        @(negedge clk);
        for (int i = 0; i < 10; i++) pushWord(0, fifo_word_t'(8'hA0 + i));
        rdcnt = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, 1'b0, 1'b0);
            if (fifo_rd_en[0]) rdcnt++;
            if (c >= 2) begin
                checkOutput($sformatf("t2_stall%0d_valid", c), 32'(m_valid[0]), 32'd1);
                checkOutput($sformatf("t2_stall%0d_data", c),  32'(m_data[0]),  32'hA0);
            end
            @(negedge clk);
        end
        checkOutput("t2_stall_reads", 32'(rdcnt), 32'd2);
        for (int c = 0; c < 11; c++) begin
            applyStimulus(0, 1'b1, 1'b0);
            if (fifo_rd_en[0]) rdcnt++;
            if (c < 10) begin
                checkOutput($sformatf("t2_run%0d_valid", c), 32'(m_valid[0]), 32'd1);
                checkOutput($sformatf("t2_run%0d_data", c),  32'(m_data[0]),  32'(8'hA0 + c));
            end else begin
                checkOutput("t2_end_valid", 32'(m_valid[0]),   32'd0);
                checkOutput("t2_pop_count", 32'(pop_count[0]), 32'd13);
            end
            @(negedge clk);
        end
        checkOutput("t2_total_reads", 32'(rdcnt), 32'd10);

        // Test 4: flush with a word in flight, on the BUF_D=3 instance.
        $display("[TB] test 4: flush with in-flight word (BUF_D=3)");
        for (int i = 0; i < 5; i++) pushWord(1, fifo_word_t'(8'hC0 + i));
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, t4[i].ready, t4[i].fl);
            checkRow(1, t4[i], $sformatf("t4_row%0d", i));
            @(negedge clk);
        end
        applyStimulus(1, 1'b0, 1'b0);

        // Test 6: asynchronous reset in mid-burst while m_valid and a read are
        // both active.
        $display("[TB] test 6: async reset mid-burst");
        for (int i = 0; i < 6; i++) pushWord(0, fifo_word_t'(8'hB0 + i));
        for (int c = 0; c < 2; c++) begin
            applyStimulus(0, 1'b1, 1'b0);
            @(negedge clk);
        end
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("t6_pre_valid", 32'(m_valid[0]), 32'd1);
        checkOutput("t6_pre_data",  32'(m_data[0]),  32'hB0);
        checkOutput("t6_pre_idle",  32'(idle[0]),    32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_rd_en", 32'(fifo_rd_en[0]), 32'd0);
        checkOutput("t6_rst_valid", 32'(m_valid[0]),    32'd0);
        checkOutput("t6_rst_data",  32'(m_data[0]),     32'd0);
        checkOutput("t6_rst_idle",  32'(idle[0]),       32'd1);
        checkOutput("t6_rst_pop",   32'(pop_count[0]),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 1'b1, 1'b0);
            checkOutput($sformatf("t6_post%0d_valid", c), 32'(m_valid[0]),    32'd0);
            checkOutput($sformatf("t6_post%0d_rd_en", c), 32'(fifo_rd_en[0]), 32'd0);
            @(negedge clk);
        end
        pushWord(0, 8'h5A);
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("t6_refill_rd_en", 32'(fifo_rd_en[0]), 32'd1);
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("t6_refill_lat_valid", 32'(m_valid[0]), 32'd0);
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("t6_refill_valid", 32'(m_valid[0]), 32'd1);
        checkOutput("t6_refill_data",  32'(m_data[0]),  32'h5A);
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("t6_refill_pop", 32'(pop_count[0]), 32'd1);

        // Test 5: 65537 transfers starting from reset, which must wrap
        // pop_count around to 1.
        $display("[TB] test 5: pop_count wrap");
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("t5_reset_pop", 32'(pop_count[0]), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        endless = 1'b1;
        pops = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 70000) begin
            applyStimulus(0, 1'b1, 1'b0);
            if (pops == 65535)
                checkOutput("t5_pop_max", 32'(pop_count[0]), 32'h0000FFFF);
            if (pops == 65536)
                checkOutput("t5_pop_wrap0", 32'(pop_count[0]), 32'd0);
            if (m_valid[0]) pops++;
            if (pops == 65537) done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        checkOutput("t5_transfers", 32'(pops), 32'd65537);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("t5_pop_count", 32'(pop_count[0]), 32'd1);
        endless = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
